troca_contexto: RTL
===================

# troca_contexto

Context-switch sequencer for the 32-entry register bank. On command, it either saves general registers $0..$30 to a data-memory context area, or restores them from that area. It owns one bank read port and the bank write port, plus one data-memory port, while `ocupado` is high. Top-level muxes give the pipeline those ports whenever `ocupado` is low.

## Interface
- `DATA_WIDTH`, 32, register and memory word width.
- `DATA_ADDR_WIDTH`, 13, data-memory word-address width.
- `NUM_REGS`, 31, registers transferred ($0..NUM_REGS-1); $31 is hardwired zero and is never transferred.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `salvar`  in  1  start save (bank → memory); sampled only in OCIOSO.
- `restaurar`  in  1  start restore (memory → bank); sampled only in OCIOSO.
- `endereco_base`  in  DATA_ADDR_WIDTH  context-area base; latched at start.
- `ocupado`  out  1  controller owns bank and memory ports.
- `concluido`  out  1  one-cycle completion pulse.
- `erro_checksum`  out  1  restore checksum mismatch, valid with `concluido`.
- `reg_leitura`  out  5  bank read address (drives `reg1`).
- `dado_reg`  in  DATA_WIDTH  bank read data (`dado1`, asynchronous).
- `reg_write`  out  1  bank write enable.
- `reg_escrita`  out  5  bank write address.
- `escreve_dado`  out  DATA_WIDTH  bank write data.
- `mem_endereco`  out  DATA_ADDR_WIDTH  memory word address.
- `mem_escrita`  out  1  memory write enable.
- `mem_dado_escrita`  out  DATA_WIDTH  memory write data.
- `mem_dado_leitura`  in  DATA_WIDTH  memory read data; synchronous, 1-cycle latency.

## Operation
- States: OCIOSO, SALVA, RESTAURA, FIM.
- **OCIOSO**
  - `salvar` → SALVA; otherwise `restaurar` → RESTAURA.
  - Both high: save wins, restore is dropped.
  - `endereco_base` is latched into `base`; index counters are cleared.
- **SALVA**, one register per cycle, for i = 0..NUM_REGS-1:
  - `reg_leitura`=i, `mem_endereco`=base+i, `mem_escrita`=1, `mem_dado_escrita`=`dado_reg`.
  - After i=NUM_REGS-1 → FIM.
- **RESTAURA**, two-stage pipeline:
  - Issue counter `k` drives `mem_endereco`=base+k for k = 0..NUM_REGS-1.
  - Write counter `j` lags `k` by one cycle: `reg_write`=1, `reg_escrita`=j, `escreve_dado`=`mem_dado_leitura`.
  - After j=NUM_REGS-1 is written → FIM.
- **FIM**
  - `concluido`=1 for one cycle, then → OCIOSO.
  - Start inputs are ignored in SALVA, RESTAURA and FIM.
- Address arithmetic: base+i truncated to DATA_ADDR_WIDTH, so the context area wraps modulo 2^DATA_ADDR_WIDTH.
- Reset at any time:
  - Next state is OCIOSO. `ocupado`, `concluido`, `erro_checksum`, `reg_write` and `mem_escrita` = 0.
  - `reg_leitura`, `reg_escrita`, `mem_endereco`, `escreve_dado` and `mem_dado_escrita` = 0.
  - Partially transferred data is not rolled back.
- When not in SALVA, `mem_escrita`=0. When not in the restore write stage, `reg_write`=0.

## Timing
Start sampled at edge E0; cycle n is the cycle after edge En-1.
- **Save**
  - `ocupado` is high in cycles 1..NUM_REGS+1; register i is transferred in cycle i+1.
  - `concluido` is high in cycle NUM_REGS+1 (cycle 32 at default).
- **Restore**
  - Address k is issued in cycle k+1.
  - Register j is written in cycle j+2 and is visible in the bank from cycle j+3.
  - `concluido` is high in cycle NUM_REGS+2 (cycle 33 at default).
- A new start is accepted at the first edge where the state is OCIOSO; back-to-back operations therefore have one idle cycle between `concluido` and the next `ocupado`.
- All outputs are combinational functions of state and counters. No output depends combinationally on `salvar` or `restaurar`.

## Configuration
- **`TROCA_CONTEXTO_CHECKSUM_EN` defined**
  - Save: a running XOR of all saved words is kept. One extra SALVA cycle writes it to base+NUM_REGS, so `concluido` moves one cycle later (cycle 33).
  - Restore: NUM_REGS+1 words are read. The XOR of the restored words is compared with the word at base+NUM_REGS, and that word is never written to the bank.
  - `erro_checksum` equals the mismatch result, registered and held from FIM until the next start or reset. `concluido` moves to cycle 34.
- **`TROCA_CONTEXTO_CHECKSUM_EN` not defined**
  - No checksum logic. `erro_checksum` is tied 0.
  - Latencies are as stated under Timing.

## Test plan
- **Save:** bank preloaded with reg i = 0x1000+i, `endereco_base`=0x0100, `salvar` pulse → memory 0x0100..0x011E holds 0x1000..0x101E; `concluido` in cycle 32; $31 untouched.
- **Restore:** memory 0x0200+i = 0xA5A50000+i, `restaurar` pulse → bank reg i = 0xA5A50000+i for i ≤ 30; `reg_write` high in cycles 2..32; `concluido` in cycle 33.
- **Simultaneous start and wrap:** `salvar`=`restaurar`=1 with `endereco_base`=0x1FF0 → only save runs; register 16 lands at address 0x0000 (wrap); no `reg_write` pulses.
- **Reset and ignored starts:** `reset` asserted in restore cycle 10 → next cycle all outputs 0 and state OCIOSO; registers 0..7 restored, registers 8..30 unchanged. Separately, starts pulsed during `ocupado` are ignored.
- **Checksum (macro defined):** save, then corrupt memory word base+5, then restore → `erro_checksum`=1 with `concluido` in cycle 34. An uncorrupted round-trip gives `erro_checksum`=0.

Source files
------------

// File: rtl/troca_contexto.sv
// ---------------------------------------------------------------------------
// troca_contexto
//
// Context-switch sequencer for the 32-entry register bank. A save copies
// registers $0..NUM_REGS-1 to a data-memory context area at a latched base.
// A restore copies them back from that area. $31 is hardwired zero and is
// never moved. While `ocupado` is high this block owns one bank read port,
// the bank write port and one data-memory port. The top level hands those
// ports to the pipeline whenever `ocupado` is low.
//
// Optional feature (macro TROCA_CONTEXTO_CHECKSUM_EN):
//   A save also writes the XOR of all saved words to base+NUM_REGS. A restore
//   reads that extra word, compares it with the XOR of the restored words,
//   and reports the result on `erro_checksum`. That word is never written to
//   the bank.
//
// Ports:
//   clock, reset       clock; synchronous active-high reset
//   salvar, restaurar  start save / start restore (sampled only when idle)
//   endereco_base      context-area base word address (latched at start)
//   ocupado            controller owns the bank and memory ports
//   concluido          one-cycle completion pulse
//   erro_checksum      restore checksum mismatch (0 without the macro)
//   reg_leitura        bank read address;  dado_reg = asynchronous read data
//   reg_write          bank write enable
//   reg_escrita        bank write address
//   escreve_dado       bank write data
//   mem_endereco       memory word address
//   mem_escrita        memory write enable
//   mem_dado_escrita   memory write data
//   mem_dado_leitura   memory read data (synchronous, 1-cycle latency)
// ---------------------------------------------------------------------------
module troca_contexto #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 13,
    parameter int NUM_REGS        = 31
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       salvar,
    input  logic                       restaurar,
    input  logic [DATA_ADDR_WIDTH-1:0] endereco_base,
    output logic                       ocupado,
    output logic                       concluido,
    output logic                       erro_checksum,
    output logic [4:0]                 reg_leitura,
    input  logic [DATA_WIDTH-1:0]      dado_reg,
    output logic                       reg_write,
    output logic [4:0]                 reg_escrita,
    output logic [DATA_WIDTH-1:0]      escreve_dado,
    output logic [DATA_ADDR_WIDTH-1:0] mem_endereco,
    output logic                       mem_escrita,
    output logic [DATA_WIDTH-1:0]      mem_dado_escrita,
    input  logic [DATA_WIDTH-1:0]      mem_dado_leitura
);

    // Number of memory words moved per operation.
`ifdef TROCA_CONTEXTO_CHECKSUM_EN
    localparam int N_PAL = NUM_REGS + 1;
`else
    localparam int N_PAL = NUM_REGS;
`endif
    localparam int            CW     = 6;
    localparam logic [CW-1:0] ULTIMO = CW'(N_PAL - 1);
    localparam logic [CW-1:0] LIMITE = CW'(N_PAL);
    localparam logic [CW-1:0] NREGS  = CW'(NUM_REGS);

    typedef enum logic [1:0] {OCIOSO, SALVA, RESTAURA, FIM} estado_t;

    estado_t                    estado_q;
    logic [CW-1:0]              idx_q;     // save index i / restore issue index k
    logic [CW-1:0]              wr_idx_q;  // restore write index j (k delayed by one)
    logic                       wr_vld_q;  // memory read data valid for index wr_idx_q
    logic [DATA_ADDR_WIDTH-1:0] base_q;
`ifdef TROCA_CONTEXTO_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]      xor_q;
    logic                       erro_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            idx_q    <= '0;
            wr_idx_q <= '0;
            wr_vld_q <= 1'b0;
            base_q   <= '0;
`ifdef TROCA_CONTEXTO_CHECKSUM_EN
            xor_q    <= '0;
            erro_q   <= 1'b0;
`endif
        end else begin
            case (estado_q)
                OCIOSO: begin
                    idx_q    <= '0;
                    wr_idx_q <= '0;
                    wr_vld_q <= 1'b0;
                    base_q   <= endereco_base;
`ifdef TROCA_CONTEXTO_CHECKSUM_EN
                    xor_q    <= '0;
                    if (salvar || restaurar) erro_q <= 1'b0;
`endif
                    // Save has priority when both starts arrive together.
                    if (salvar)         estado_q <= SALVA;
                    else if (restaurar) estado_q <= RESTAURA;
                end
                SALVA: begin
                    idx_q <= idx_q + 1'b1;
`ifdef TROCA_CONTEXTO_CHECKSUM_EN
                    if (idx_q < NREGS) xor_q <= xor_q ^ dado_reg;
`endif
                    if (idx_q == ULTIMO) estado_q <= FIM;
                end
                RESTAURA: begin
                    // Issue stage: stop advancing once every word is requested.
                    if (idx_q < LIMITE) idx_q <= idx_q + 1'b1;
                    wr_vld_q <= (idx_q < LIMITE);
                    wr_idx_q <= idx_q;
                    // Write stage: data for wr_idx_q arrives this cycle.
                    if (wr_vld_q) begin
`ifdef TROCA_CONTEXTO_CHECKSUM_EN
                        if (wr_idx_q < NREGS) xor_q <= xor_q ^ mem_dado_leitura;
                        else                  erro_q <= (xor_q != mem_dado_leitura);
`endif
                        if (wr_idx_q == ULTIMO) estado_q <= FIM;
                    end
                end
                FIM:     estado_q <= OCIOSO;
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    // Outputs decode state and counters only. Write enables are also
    // suppressed while reset is high, so an aborting cycle commits nothing.
    always_comb begin
        ocupado          = 1'b0;
        concluido        = 1'b0;
        reg_leitura      = '0;
        reg_write        = 1'b0;
        reg_escrita      = '0;
        escreve_dado     = '0;
        mem_endereco     = '0;
        mem_escrita      = 1'b0;
        mem_dado_escrita = '0;
        case (estado_q)
            SALVA: begin
                ocupado          = 1'b1;
                reg_leitura      = idx_q[4:0];
                mem_endereco     = base_q + DATA_ADDR_WIDTH'(idx_q);
                mem_escrita      = ~reset;
                mem_dado_escrita = dado_reg;
`ifdef TROCA_CONTEXTO_CHECKSUM_EN
                if (idx_q == NREGS) mem_dado_escrita = xor_q;
`endif
            end
            RESTAURA: begin
                ocupado      = 1'b1;
                mem_endereco = base_q + DATA_ADDR_WIDTH'(idx_q);
                if (wr_vld_q && (wr_idx_q < NREGS)) begin
                    reg_write    = ~reset;
                    reg_escrita  = wr_idx_q[4:0];
                    escreve_dado = mem_dado_leitura;
                end
            end
            FIM: begin
                ocupado   = 1'b1;
                concluido = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef TROCA_CONTEXTO_CHECKSUM_EN
    assign erro_checksum = erro_q;
`else
    assign erro_checksum = 1'b0;
`endif

endmodule
